// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage with req/ack imem port and IF/ID register.
// Optional IF_PERF_CNT_EN adds fetch_cnt_out / stall_cnt_out counters.
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif

module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        stall_in,
   input  logic                        flush_in,
   input  logic [31:0]                 redirect_pc_in,
   output logic                        imem_req_out,
   output logic [31:0]                 imem_addr_out,
   input  logic                        imem_ack_in,
   input  logic [`INST_DATA_WIDTH-1:0] imem_data_in,
   output logic                        inst_valid_out,
   output logic [`INST_DATA_WIDTH-1:0] inst_data_out,
   output logic [31:0]                 inst_pc_out
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]                 fetch_cnt_out,
   output logic [31:0]                 stall_cnt_out
`endif
);

   localparam int W = `INST_DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD,
      DROP
   } state_t;

   state_t        state_q;
   logic [31:0]   pc_q;
   logic [31:0]   drop_addr_q;
   logic          out_valid_q;
   logic [W-1:0]  out_data_q;
   logic [31:0]   out_pc_q;
   logic [W-1:0]  hold_data_q;
   logic [31:0]   hold_pc_q;
   logic [31:0]   pc_inc_d;
   logic          slot_free_d;

   assign pc_inc_d    = pc_q + 32'd4;
   assign slot_free_d = !stall_in || !out_valid_q;

   // A DROP request keeps the pre-flush address until its ack arrives.
   assign imem_req_out  = (state_q == REQ) || (state_q == DROP);
   assign imem_addr_out = (state_q == DROP) ? drop_addr_q : pc_q;

   assign inst_valid_out = out_valid_q;
   assign inst_data_out  = out_data_q;
   assign inst_pc_out    = out_pc_q;

   // Fetch FSM, PC, IF/ID slot and one-entry hold buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         drop_addr_q <= RESET_PC;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_pc_q    <= '0;
         hold_data_q <= '0;
         hold_pc_q   <= '0;
      end else if (flush_in) begin
         out_valid_q <= 1'b0;
         hold_data_q <= '0;
         hold_pc_q   <= '0;
         pc_q        <= redirect_pc_in;
         unique case (state_q)
            REQ: begin
               if (!imem_ack_in) begin
                  state_q     <= DROP;
                  drop_addr_q <= pc_q;
               end
            end
            DROP: begin
               if (imem_ack_in) state_q <= REQ;
            end
            default: state_q <= REQ;
         endcase
      end else begin
         unique case (state_q)
            IDLE: begin
               state_q <= REQ;
               if (!stall_in) out_valid_q <= 1'b0;
            end
            REQ: begin
               if (imem_ack_in) begin
                  pc_q <= pc_inc_d;
                  if (slot_free_d) begin
                     out_valid_q <= 1'b1;
                     out_data_q  <= imem_data_in;
                     out_pc_q    <= pc_q;
                  end else begin
                     hold_data_q <= imem_data_in;
                     hold_pc_q   <= pc_q;
                     state_q     <= HOLD;
                  end
               end else if (!stall_in) begin
                  out_valid_q <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall_in) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= hold_data_q;
                  out_pc_q    <= hold_pc_q;
                  state_q     <= REQ;
               end
            end
            DROP: begin
               if (imem_ack_in) state_q <= REQ;
               if (!stall_in) out_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;

   assign fetch_cnt_out = fetch_cnt_q;
   assign stall_cnt_out = stall_cnt_q;

   // Count accepted fetches and cycles where decode holds a valid slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (!flush_in && (state_q == REQ) && imem_ack_in)
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (stall_in && out_valid_q)
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end
`endif

endmodule
